// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the serial audio frame receiver.
//   rx_state_e : receiver FSM states (IDLE is the all-zero reset encoding)
//   fb_w()     : width of the in-frame bit index for a given slot layout
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    RUN  = 2'd2
  } rx_state_e;

  function automatic int fb_w(input int channels, input int slot_bits);
    return $clog2(channels * slot_bits);
  endfunction

endpackage

// File: rtl/i2s_rx_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
// The detector's history flop only advances when sample_i is high, so an
// edge is reported relative to the previous *sampled* value. Tied high, this
// is a plain per-cycle edge detect (used for BCLK); driven by the BCLK rise
// strobe, it finds an FS 0->1 as seen on consecutive BCLK rises.
// Ports:
//   clk_i    in  sampling clock
//   rst_n_i  in  asynchronous active-low reset
//   d_i      in  asynchronous input
//   sample_i in  qualifies the edge detector
//   rise_o   out one-cycle pulse: synchronised input is 1, previous sample was 0
module i2s_rx_edge_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  input  logic sample_i,
  output logic rise_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
    prev_d = sample_i ? sync_q[1] : prev_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values; combinational blocks use blocking ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sample_i & sync_q[1] & ~prev_q;

endmodule

// File: rtl/i2s_tdm_frame_receiver.sv
// Multi-slot serial audio receiver (MSB-justified or I2S, stereo or TDM).
// Oversamples BCLK/FS/DATA in the clk_x4_i domain, checks frame alignment
// against FS and streams every received bit into a 1-bit-wide circular frame
// RAM addressed {frame_idx, bit_idx}. The index of the last complete,
// alignment-checked frame is published for the downstream framer.
// Optional feature: define I2S_RX_ERR_CNT_EN to add err_count_o, a 16-bit
// saturating count of frame_err_o pulses (cleared only by reset).
// Ports:
//   clk_x4_i              in  system clock, >= 4x BCLK
//   rst_n_i               in  asynchronous active-low reset
//   enable_i              in  receiver enable
//   i2s_bclk_i            in  serial bit clock
//   i2s_fs_i              in  frame sync; rising edge marks the frame start
//   i2s_data_i            in  serial data
//   ram_write_addr_o      out {frame_idx, bit_idx}
//   ram_write_en_o        out one-cycle write strobe
//   ram_write_data_o      out received bit
//   last_good_frame_idx_o out last fully received, error-free frame
//   frame_valid_o         out sticky: at least one good frame completed
//   locked_o              out high while in RUN
//   frame_err_o           out one-cycle pulse on an FS misalignment
//   err_count_o           out saturating error count (I2S_RX_ERR_CNT_EN only)
module i2s_tdm_frame_receiver
  import i2s_rx_pkg::*;
#(
  parameter int CIRC_BUF_BITS = 3,
  parameter int CHANNELS      = 8,
  parameter int SLOT_BITS     = 32,
  parameter int FS_DELAY      = 0
) (
  input  logic                                                clk_x4_i,
  input  logic                                                rst_n_i,
  input  logic                                                enable_i,
  input  logic                                                i2s_bclk_i,
  input  logic                                                i2s_fs_i,
  input  logic                                                i2s_data_i,
  output logic [CIRC_BUF_BITS+fb_w(CHANNELS, SLOT_BITS)-1:0] ram_write_addr_o,
  output logic                                                ram_write_en_o,
  output logic                                                ram_write_data_o,
  output logic [CIRC_BUF_BITS-1:0]                            last_good_frame_idx_o,
  output logic                                                frame_valid_o,
  output logic                                                locked_o,
  output logic                                                frame_err_o
`ifdef I2S_RX_ERR_CNT_EN
  ,
  output logic [15:0]                                         err_count_o
`endif
);

  localparam int FRAME_BITS = CHANNELS * SLOT_BITS;
  localparam int FB_W       = fb_w(CHANNELS, SLOT_BITS);
  localparam int AW         = CIRC_BUF_BITS + FB_W;
  localparam logic [FB_W-1:0] LAST_BIT = FB_W'(FRAME_BITS - 1);

  if ((FRAME_BITS < 2) || ((FRAME_BITS & (FRAME_BITS - 1)) != 0)) begin : g_chk_frame_bits
    $error("CHANNELS*SLOT_BITS must be a power of 2");
  end
  if ((FS_DELAY != 0) && (FS_DELAY != 1)) begin : g_chk_fs_delay
    $error("FS_DELAY must be 0 or 1");
  end

  // ---------------------------------------------------------------------------
  // Input synchronisation: BCLK, FS and DATA all see two flops so that FS and
  // DATA sampled on the BCLK rise cycle line up with the edge that clocked them.
  // ---------------------------------------------------------------------------
  logic       bclk_rise;
  logic       fs_rise;
  logic [1:0] data_sync_q, data_sync_d;
  logic       data_bit;
  logic       sof;

  i2s_rx_edge_sync u_bclk_sync (
    .clk_i    (clk_x4_i),
    .rst_n_i  (rst_n_i),
    .d_i      (i2s_bclk_i),
    .sample_i (1'b1),
    .rise_o   (bclk_rise)
  );

  i2s_rx_edge_sync u_fs_sync (
    .clk_i    (clk_x4_i),
    .rst_n_i  (rst_n_i),
    .d_i      (i2s_fs_i),
    .sample_i (bclk_rise),
    .rise_o   (fs_rise)
  );

  always_comb data_sync_d = {data_sync_q[0], i2s_data_i};
  assign data_bit = data_sync_q[1];

  if (FS_DELAY == 1) begin : g_sof_i2s
    // I2S: the MSB follows the FS edge by one BCLK, so hold the edge until
    // the next rise.
    logic sof_pend_q, sof_pend_d;
    always_comb sof_pend_d = bclk_rise ? fs_rise : sof_pend_q;
    always_ff @(posedge clk_x4_i or negedge rst_n_i) begin
      if (!rst_n_i) sof_pend_q <= 1'b0;
      else          sof_pend_q <= sof_pend_d;
    end
    assign sof = bclk_rise & sof_pend_q;
  end else begin : g_sof_lj
    assign sof = fs_rise;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and RAM write port
  // ---------------------------------------------------------------------------
  rx_state_e                state_q, state_d;
  logic [FB_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [CIRC_BUF_BITS-1:0] frame_idx_q, frame_idx_d;
  logic [CIRC_BUF_BITS-1:0] last_good_q, last_good_d;
  logic                     frame_valid_q, frame_valid_d;
  logic                     wr_en_q, wr_en_d;
  logic [AW-1:0]            wr_addr_q, wr_addr_d;
  logic                     wr_data_q, wr_data_d;
  logic                     frame_err_q, frame_err_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    frame_idx_d   = frame_idx_q;
    last_good_d   = last_good_q;
    frame_valid_d = frame_valid_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable_i) state_d = HUNT;
      end
      HUNT: begin
        if (enable_i && sof) begin
          state_d   = RUN;
          bit_cnt_d = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = {frame_idx_q, {FB_W{1'b0}}};
          wr_data_d = data_bit;
        end
      end
      RUN: begin
        if (bclk_rise) begin
          // A frame boundary must coincide with FS exactly; either one
          // without the other is a misalignment.
          if (sof ^ (bit_cnt_q == LAST_BIT)) begin
            if (enable_i) begin
              frame_err_d = 1'b1;
              state_d     = HUNT;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            // The final bit of a frame is still committed if enable_i drops
            // on that very cycle; any other bit is dropped with the frame.
            if (enable_i || (bit_cnt_d == LAST_BIT)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = {frame_idx_q, bit_cnt_d};
              wr_data_d = data_bit;
            end
            if (bit_cnt_d == LAST_BIT) begin
              last_good_d   = frame_idx_q;
              frame_idx_d   = frame_idx_q + 1'b1;
              frame_valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable_i) state_d = IDLE;
  end

  always_ff @(posedge clk_x4_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_sync_q   <= '0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      frame_idx_q   <= '0;
      last_good_q   <= '0;
      frame_valid_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      data_sync_q   <= data_sync_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_idx_q   <= frame_idx_d;
      last_good_q   <= last_good_d;
      frame_valid_q <= frame_valid_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign ram_write_addr_o      = wr_addr_q;
  assign ram_write_en_o        = wr_en_q;
  assign ram_write_data_o      = wr_data_q;
  assign last_good_frame_idx_o = last_good_q;
  assign frame_valid_o         = frame_valid_q;
  assign locked_o              = (state_q == RUN);
  assign frame_err_o           = frame_err_q;

`ifdef I2S_RX_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_x4_i or negedge rst_n_i) begin
    if (!rst_n_i) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tdm_frame_receiver.sv
// Self-checking bench for i2s_tdm_frame_receiver.
// dut0: 8 slots x 32 bits, MSB-justified. dut1: stereo 2 x 32 bits, I2S.
// Random frame payloads; a frame-level model predicts every RAM write,
// the published frame index, validity, lock state and error pulses.
`timescale 1ns/1ps
module tb_i2s_tdm_frame_receiver;

  localparam int CBB   = 3;
  localparam int NFRM  = 1 << CBB;
  localparam int FB0   = 256;
  localparam int AW0   = CBB + 8;
  localparam int FB1   = 64;
  localparam int AW1   = CBB + 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en, bclk, fs, data;

  always #5 clk = ~clk;

  logic [AW0-1:0] addr0;
  logic [AW1-1:0] addr1;
  logic           wen0, wen1, wd0, wd1, valid0, valid1, lock0, lock1, ferr0, ferr1;
  logic [CBB-1:0] last0, last1;
`ifdef I2S_RX_ERR_CNT_EN
  logic [15:0]    ecnt0, ecnt1;
`endif

  i2s_tdm_frame_receiver #(
    .CIRC_BUF_BITS (CBB), .CHANNELS (8), .SLOT_BITS (32), .FS_DELAY (0)
  ) dut0 (
    .clk_x4_i              (clk),
    .rst_n_i               (rst_n),
    .enable_i              (en[0]),
    .i2s_bclk_i            (bclk[0]),
    .i2s_fs_i              (fs[0]),
    .i2s_data_i            (data[0]),
    .ram_write_addr_o      (addr0),
    .ram_write_en_o        (wen0),
    .ram_write_data_o      (wd0),
    .last_good_frame_idx_o (last0),
    .frame_valid_o         (valid0),
    .locked_o              (lock0),
    .frame_err_o           (ferr0)
`ifdef I2S_RX_ERR_CNT_EN
    ,
    .err_count_o           (ecnt0)
`endif
  );

  i2s_tdm_frame_receiver #(
    .CIRC_BUF_BITS (CBB), .CHANNELS (2), .SLOT_BITS (32), .FS_DELAY (1)
  ) dut1 (
    .clk_x4_i              (clk),
    .rst_n_i               (rst_n),
    .enable_i              (en[1]),
    .i2s_bclk_i            (bclk[1]),
    .i2s_fs_i              (fs[1]),
    .i2s_data_i            (data[1]),
    .ram_write_addr_o      (addr1),
    .ram_write_en_o        (wen1),
    .ram_write_data_o      (wd1),
    .last_good_frame_idx_o (last1),
    .frame_valid_o         (valid1),
    .locked_o              (lock1),
    .frame_err_o           (ferr1)
`ifdef I2S_RX_ERR_CNT_EN
    ,
    .err_count_o           (ecnt1)
`endif
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: expected write list ({addr, bit}) filled by the stimulus
  // process, consumed in order by the monitor.
  // ---------------------------------------------------------------------------
  int exp0[8192];
  int exp1[512];
  int wp0 = 0, wp1 = 0;   // written by stimulus
  int rp0 = 0, rp1 = 0;   // written by monitor
  int wr_cnt0 = 0, wr_cnt1 = 0;
  int seen_err0 = 0, seen_err1 = 0;

  int m_idx[2], m_last[2], m_err_tot[2], m_err_rst[2];
  bit m_valid[2], m_lock[2];
  bit fbits[FB0];

  function automatic void exp_push(input int u, input int addr, input bit d);
    if (u == 0) begin exp0[wp0] = (addr << 1) | int'(d); wp0++; end
    else        begin exp1[wp1] = (addr << 1) | int'(d); wp1++; end
  endfunction

  function automatic void model_complete(input int u);
    m_last[u]  = m_idx[u];
    m_idx[u]   = (m_idx[u] + 1) % NFRM;
    m_valid[u] = 1'b1;
  endfunction

  function automatic void model_error(input int u);
    m_err_tot[u]++;
    m_err_rst[u]++;
    m_lock[u] = 1'b0;
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      m_idx[u] = 0; m_last[u] = 0; m_valid[u] = 1'b0; m_lock[u] = 1'b0; m_err_rst[u] = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (wen0) begin
      if (rp0 >= wp0) check("dut0_unexpected_wr", wen0, 0);
      else begin check($sformatf("dut0_wr%0d", rp0), {addr0, wd0}, exp0[rp0]); rp0++; end
      wr_cnt0++;
    end
    if (wen1) begin
      if (rp1 >= wp1) check("dut1_unexpected_wr", wen1, 0);
      else begin check($sformatf("dut1_wr%0d", rp1), {addr1, wd1}, exp1[rp1]); rp1++; end
      wr_cnt1++;
    end
    if (ferr0) seen_err0++;
    if (ferr1) seen_err1++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // One BCLK period (4 clk cycles); FS and DATA change with the falling edge.
  task automatic bclk_period(input int u, input bit fs_v, input bit d_v);
    @(negedge clk);
    bclk[u] = 1'b0; fs[u] = fs_v; data[u] = d_v;
    @(negedge clk);
    @(negedge clk);
    bclk[u] = 1'b1;
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  // Bits [first, stop) of an MSB-justified frame on dut0 (FS high for the first
  // half). A new random payload is drawn when first == 0.
  task automatic lj_bits(input int first, input int stop, input bit capture);
    if (first == 0) for (int k = 0; k < FB0; k++) fbits[k] = 1'($urandom_range(0, 1));
    if (capture) begin
      if (first == 0) m_lock[0] = 1'b1;
      for (int k = first; k < stop; k++) exp_push(0, m_idx[0] * FB0 + k, fbits[k]);
    end
    for (int k = first; k < stop; k++) bclk_period(0, k < FB0 / 2, fbits[k]);
  endtask

  // One full I2S stereo frame on dut1: slot 0 = 0xA5A5_0001, slot 1 random,
  // MSB first; FS rises one BCLK ahead of each frame's MSB.
  task automatic i2s_frame();
    logic [31:0] slot [2];
    bit          b;
    slot[0] = 32'hA5A5_0001;
    slot[1] = $urandom;
    m_lock[1] = 1'b1;
    for (int k = 0; k < FB1; k++) begin
      b = slot[k / 32][31 - (k % 32)];
      exp_push(1, m_idx[1] * FB1 + k, b);
    end
    for (int k = 0; k < FB1; k++) begin
      b = slot[k / 32][31 - (k % 32)];
      bclk_period(1, ((k + 1) % FB1) < FB1 / 2, b);
    end
  endtask

  task automatic check_status(input int u, input string tag);
    if (u == 0) begin
      check({tag, "_last"},  last0,     m_last[0]);
      check({tag, "_valid"}, valid0,    m_valid[0]);
      check({tag, "_lock"},  lock0,     m_lock[0]);
      check({tag, "_errs"},  seen_err0, m_err_tot[0]);
    end else begin
      check({tag, "_last"},  last1,     m_last[1]);
      check({tag, "_valid"}, valid1,    m_valid[1]);
      check({tag, "_lock"},  lock1,     m_lock[1]);
      check({tag, "_errs"},  seen_err1, m_err_tot[1]);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wen0"},  wen0,   0);
    check({tag, "_addr0"}, addr0,  0);
    check({tag, "_wd0"},   wd0,    0);
    check({tag, "_last0"}, last0,  0);
    check({tag, "_val0"},  valid0, 0);
    check({tag, "_lock0"}, lock0,  0);
    check({tag, "_ferr0"}, ferr0,  0);
    check({tag, "_last1"}, last1,  0);
    check({tag, "_val1"},  valid1, 0);
    check({tag, "_lock1"}, lock1,  0);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    int c0;
    rst_n = 1'b0;
    en = '0; bclk = '0; fs = '0; data = '0;
    m_err_tot[0] = 0; m_err_tot[1] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("por");
    rst_n = 1'b1;
    settle();
    check_zero("idle");

    // Stereo I2S: bit 0 is the MSB of slot 0, 64 writes per frame.
    en[1] = 1'b1;
    settle();
    check_status(1, "i2s_hunt");
    bclk_period(1, 1'b0, 1'b0);
    bclk_period(1, 1'b1, 1'b0);
    for (int f = 0; f < 3; f++) begin
      c0 = wr_cnt1;
      i2s_frame();
      settle();
      model_complete(1);
      check_status(1, $sformatf("i2s_f%0d", f));
      check($sformatf("i2s_f%0d_writes", f), wr_cnt1 - c0, FB1);
    end
    en[1] = 1'b0;
    settle();
    m_lock[1] = 1'b0;
    check_status(1, "i2s_off");

    // TDM 8x32: three clean frames.
    en[0] = 1'b1;
    settle();
    check_status(0, "tdm_hunt");
    bclk_period(0, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) begin
      c0 = wr_cnt0;
      lj_bits(0, FB0, 1'b1);
      settle();
      model_complete(0);
      check_status(0, $sformatf("tdm_f%0d", f));
      check($sformatf("tdm_f%0d_writes", f), wr_cnt0 - c0, FB0);
    end

    // FS arrives 5 BCLKs early: partial frame, one error, the frame started
    // by that FS is skipped while hunting, the next one reuses the index.
    lj_bits(0, FB0 - 5, 1'b1);
    model_error(0);
    lj_bits(0, FB0, 1'b0);
    settle();
    check_status(0, "early_fs");
`ifdef I2S_RX_ERR_CNT_EN
    check("early_fs_errcnt", ecnt0, m_err_rst[0]);
`endif
    lj_bits(0, FB0, 1'b1);
    settle();
    model_complete(0);
    check_status(0, "relock");

    // Run past the end of the circular buffer.
    for (int f = 0; f < 5; f++) begin
      lj_bits(0, FB0, 1'b1);
      settle();
      model_complete(0);
      check_status(0, $sformatf("wrap_f%0d", f));
    end

    // enable_i drops after bit 100 is written.
    lj_bits(0, 101, 1'b1);
    settle();
    en[0] = 1'b0;
    m_lock[0] = 1'b0;
    settle();
    c0 = wr_cnt0;
    lj_bits(101, FB0, 1'b0);
    settle();
    check("disabled_writes", wr_cnt0 - c0, 0);
    check_status(0, "disabled");
    en[0] = 1'b1;
    settle();
    lj_bits(0, FB0, 1'b1);
    settle();
    model_complete(0);
    check_status(0, "reenable");

    // Asynchronous reset mid-frame.
    lj_bits(0, 50, 1'b1);
    settle();
    check("pre_rst_drain0", rp0, wp0);
    #2;
    rst_n = 1'b0;
    bclk[0] = 1'b0; fs[0] = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle();
    check_status(0, "post_rst");
`ifdef I2S_RX_ERR_CNT_EN
    check("post_rst_errcnt", ecnt0, 0);
`endif

    // Three forced errors: a good frame, then a BCLK with no FS where the next
    // frame should have started.
    for (int e = 0; e < 3; e++) begin
      lj_bits(0, FB0, 1'b1);
      model_complete(0);
      bclk_period(0, 1'b0, 1'($urandom_range(0, 1)));
      settle();
      model_error(0);
      check_status(0, $sformatf("forced_err%0d", e));
`ifdef I2S_RX_ERR_CNT_EN
      check($sformatf("forced_err%0d_cnt", e), ecnt0, m_err_rst[0]);
`endif
    end

    settle();
    check("drain0", rp0, wp0);
    check("drain1", rp1, wp1);
    check("dut1_errs", seen_err1, m_err_tot[1]);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
